// File: rtl/bbox_scan.sv
// Bounding-box scanner: streams a frame out of the read port in raster order and
// reports the min/max column and row of pixels that pass the colour threshold.
module bbox_scan #(
  parameter int         H_RES      = 320,
  parameter int         V_RES      = 240,
  parameter int         RD_LATENCY = 1,
  parameter logic [3:0] R_MIN      = 4'd10,
  parameter logic [3:0] G_MAX      = 4'd6,
  parameter logic [3:0] B_MAX      = 4'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [16:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic [8:0]  x_min,
  output logic [8:0]  x_max,
  output logic [8:0]  y_min,
  output logic [8:0]  y_max,
  output logic        found,
  output logic [16:0] pix_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [8:0]  X_LAST = 9'(H_RES - 1);
  localparam logic [8:0]  Y_LAST = 9'(V_RES - 1);
  localparam logic [16:0] A_LAST = 17'(H_RES * V_RES - 1);
  localparam logic [1:0]  D_LAST = 2'(RD_LATENCY - 1);

  state_t      state_q, state_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic [16:0] addr_q, addr_d;
  logic [1:0]  drain_q, drain_d;

  logic [8:0]  acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [8:0]  acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic [16:0] acc_cnt_q, acc_cnt_d;
  logic        acc_found_q, acc_found_d;

  // Coordinates travel alongside each read so they line up with the returning data.
  logic        pipe_v_q [RD_LATENCY];
  logic [8:0]  pipe_x_q [RD_LATENCY];
  logic [8:0]  pipe_y_q [RD_LATENCY];

  logic [8:0]  xmin_q, xmax_q, ymin_q, ymax_q;
  logic [16:0] cnt_q;
  logic        found_q;

  logic        go, finish, pix_match;
  logic [8:0]  px, py;

  assign px        = pipe_x_q[RD_LATENCY-1];
  assign py        = pipe_y_q[RD_LATENCY-1];
  assign pix_match = pipe_v_q[RD_LATENCY-1] &&
                     (rd_data[11:8] >= R_MIN) &&
                     (rd_data[7:4]  <= G_MAX) &&
                     (rd_data[3:0]  <= B_MAX);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    go      = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !ack) begin
          state_d = SCAN;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          go      = 1'b1;
        end
      end
      SCAN: begin
        if (addr_q == A_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + 17'd1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 9'd1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == D_LAST) begin
          state_d = DONE;
          finish  = 1'b1;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_xmin_d  = acc_xmin_q;
    acc_xmax_d  = acc_xmax_q;
    acc_ymin_d  = acc_ymin_q;
    acc_ymax_d  = acc_ymax_q;
    acc_cnt_d   = acc_cnt_q;
    acc_found_d = acc_found_q;
    if (go) begin
      acc_xmin_d  = X_LAST;
      acc_xmax_d  = '0;
      acc_ymin_d  = Y_LAST;
      acc_ymax_d  = '0;
      acc_cnt_d   = '0;
      acc_found_d = 1'b0;
    end else if (pix_match) begin
      if (px < acc_xmin_q) acc_xmin_d = px;
      if (px > acc_xmax_q) acc_xmax_d = px;
      if (py < acc_ymin_q) acc_ymin_d = py;
      if (py > acc_ymax_q) acc_ymax_d = py;
      acc_cnt_d   = acc_cnt_q + 17'd1;
      acc_found_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      drain_q     <= '0;
      acc_xmin_q  <= '0;
      acc_xmax_q  <= '0;
      acc_ymin_q  <= '0;
      acc_ymax_q  <= '0;
      acc_cnt_q   <= '0;
      acc_found_q <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_x_q[i] <= '0;
        pipe_y_q[i] <= '0;
      end
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      cnt_q       <= '0;
      found_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      acc_xmin_q  <= acc_xmin_d;
      acc_xmax_q  <= acc_xmax_d;
      acc_ymin_q  <= acc_ymin_d;
      acc_ymax_q  <= acc_ymax_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_found_q <= acc_found_d;
      pipe_v_q[0] <= (state_q == SCAN);
      pipe_x_q[0] <= x_q;
      pipe_y_q[0] <= y_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_x_q[i] <= pipe_x_q[i-1];
        pipe_y_q[i] <= pipe_y_q[i-1];
      end
      // The last pixel lands on the same edge that enters DONE, so capture the _d values.
      if (finish) begin
        found_q <= acc_found_d;
        cnt_q   <= acc_cnt_d;
        if (acc_found_d) begin
          xmin_q <= acc_xmin_d;
          xmax_q <= acc_xmax_d;
          ymin_q <= acc_ymin_d;
          ymax_q <= acc_ymax_d;
        end else begin
          xmin_q <= '0;
          xmax_q <= '0;
          ymin_q <= '0;
          ymax_q <= '0;
        end
      end
    end
  end

  assign busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign rd_addr   = addr_q;
  assign x_min     = xmin_q;
  assign x_max     = xmax_q;
  assign y_min     = ymin_q;
  assign y_max     = ymax_q;
  assign found     = found_q;
  assign pix_count = cnt_q;

endmodule

// File: tb/tb_bbox_scan.sv
// Scoreboard bench for bbox_scan: two instances (read latency 1 and 2) share one
// frame model; a monitor compares each DONE against a frame-level reference.
module tb_bbox_scan;

  localparam int H = 8;
  localparam int V = 4;
  localparam int N = H * V;

  typedef struct {
    logic [8:0]  xmin;
    logic [8:0]  xmax;
    logic [8:0]  ymin;
    logic [8:0]  ymax;
    logic        found;
    logic [16:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic        busy_w [2];
  logic        done_w [2];
  logic        found_w [2];
  logic [16:0] rd_addr_w [2];
  logic [16:0] cnt_w [2];
  logic [11:0] rd_data_w [2];
  logic [8:0]  xmin_w [2];
  logic [8:0]  xmax_w [2];
  logic [8:0]  ymin_w [2];
  logic [8:0]  ymax_w [2];
  logic [11:0] mem [N];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [11:0] rd_pipe [2];
      bbox_scan #(
        .H_RES(H), .V_RES(V), .RD_LATENCY(gi + 1)
      ) u_dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack),
        .busy(busy_w[gi]), .done(done_w[gi]), .rd_addr(rd_addr_w[gi]),
        .rd_data(rd_data_w[gi]), .x_min(xmin_w[gi]), .x_max(xmax_w[gi]),
        .y_min(ymin_w[gi]), .y_max(ymax_w[gi]), .found(found_w[gi]),
        .pix_count(cnt_w[gi])
      );
      always @(posedge clk) begin
        rd_pipe[0] <= mem[int'(rd_addr_w[gi]) % N];
        rd_pipe[1] <= rd_pipe[0];
      end
      assign rd_data_w[gi] = (gi == 0) ? rd_pipe[0] : rd_pipe[1];
    end
  endgenerate

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", name, i, act, req);
    end
  endtask

  task automatic chk_outs(input string name, input int i, input exp_t e);
    chk({name, ".found"}, i, 32'(found_w[i]), 32'(e.found));
    chk({name, ".x_min"}, i, 32'(xmin_w[i]), 32'(e.xmin));
    chk({name, ".x_max"}, i, 32'(xmax_w[i]), 32'(e.xmax));
    chk({name, ".y_min"}, i, 32'(ymin_w[i]), 32'(e.ymin));
    chk({name, ".y_max"}, i, 32'(ymax_w[i]), 32'(e.ymax));
    chk({name, ".count"}, i, 32'(cnt_w[i]), 32'(e.cnt));
  endtask

  function automatic bit is_match(input logic [11:0] p);
    return (int'(p[11:8]) >= 10) && (int'(p[7:4]) <= 6) && (int'(p[3:0]) <= 6);
  endfunction

  // Frame-level answer: first match seeds the box, later matches widen it.
  function automatic exp_t ref_model();
    exp_t e;
    e = '{default: 0};
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (is_match(mem[y * H + x])) begin
          if (!e.found) begin
            e.xmin = 9'(x); e.xmax = 9'(x); e.ymin = 9'(y); e.ymax = 9'(y);
          end else begin
            if (x < int'(e.xmin)) e.xmin = 9'(x);
            if (x > int'(e.xmax)) e.xmax = 9'(x);
            if (y < int'(e.ymin)) e.ymin = 9'(y);
            if (y > int'(e.ymax)) e.ymax = 9'(y);
          end
          e.cnt++;
          e.found = 1'b1;
        end
      end
    end
    return e;
  endfunction

  task automatic fill(input logic [11:0] c);
    for (int i = 0; i < N; i++) mem[i] = c;
  endtask

  task automatic put(input int x, input int y, input logic [11:0] c);
    mem[y * H + x] = c;
  endtask

  task automatic push_exp();
    exp_t e;
    e = ref_model();
    exp_q0.push_back(e);
    exp_q1.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!(done_w[0] && done_w[1]) && c < 200) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (c >= 200) begin
      fails++;
      $display("FAIL %s: done not seen after %0d cycles, required within 200", name, c);
    end
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
  endtask

  task automatic do_scan(input string name);
    push_exp();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(name);
    pulse_ack();
  endtask

  // Monitor: address sequence, DONE latency and scoreboard comparison on each DONE.
  initial begin
    int   start_cyc [2];
    logic busy_prev [2];
    logic done_prev [2];
    int   k;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      start_cyc[i] = 0; busy_prev[i] = 1'b0; done_prev[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset) begin
          if (busy_w[i] && !busy_prev[i]) start_cyc[i] = cyc;
          if (busy_w[i]) begin
            k = cyc - start_cyc[i];
            if (k < N) chk("rd_addr_scan", i, 32'(rd_addr_w[i]), 32'(k));
            else       chk("rd_addr_drain", i, 32'(rd_addr_w[i]), 32'(N - 1));
          end
          if (done_w[i] && !done_prev[i]) begin
            chk("done_latency", i, 32'(cyc - start_cyc[i]), 32'(N + i + 1));
            if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
              tests++;
              fails++;
              $display("FAIL unexpected_done dut%0d: got done with no scan pending, expected none", i);
            end else begin
              e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk_outs("result", i, e);
              $display("[TB] dut%0d done: x=%0d..%0d y=%0d..%0d found=%0d count=%0d",
                       i, xmin_w[i], xmax_w[i], ymin_w[i], ymax_w[i], found_w[i], cnt_w[i]);
            end
          end
        end
        busy_prev[i] = busy_w[i];
        done_prev[i] = done_w[i];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish earlier", $time);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t old_e;
    exp_t zero_e;
    zero_e = '{default: 0};
    fill(12'h000);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset.busy", i, 32'(busy_w[i]), 0);
      chk("reset.done", i, 32'(done_w[i]), 0);
      chk("reset.rd_addr", i, 32'(rd_addr_w[i]), 0);
      chk_outs("reset", i, zero_e);
    end

    fill(12'h000); put(5, 2, 12'hF00);
    do_scan("single");
    fill(12'h000); put(1, 0, 12'hF00); put(6, 1, 12'hF00); put(3, 3, 12'hF00);
    do_scan("three");
    fill(12'h000); put(0, 0, 12'hA66); put(7, 3, 12'h966); put(2, 1, 12'hA76); put(4, 2, 12'hA67);
    do_scan("boundary");
    fill(12'h000);
    do_scan("empty");
    fill(12'hF00);
    do_scan("full");

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0)
          mem[i] = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6))};
        else
          mem[i] = 12'($urandom);
      end
      do_scan("random");
    end

    // start held high across DONE must not retrigger until ack returns to IDLE
    fill(12'h000); put(2, 1, 12'hF00); put(4, 3, 12'hF00);
    push_exp();
    old_e = ref_model();
    @(posedge clk); #1 start = 1'b1;
    wait_done("held");
    repeat (4) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        chk("held.done", i, 32'(done_w[i]), 1);
        chk("held.busy", i, 32'(busy_w[i]), 0);
      end
    end
    fill(12'h000); put(7, 0, 12'hF00);
    push_exp();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("ack.done", i, 32'(done_w[i]), 0);
      chk("ack.busy", i, 32'(busy_w[i]), 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rescan.busy", i, 32'(busy_w[i]), 1);
      chk_outs("rescan_hold", i, old_e);
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk_outs("midscan_hold", i, old_e);
    wait_done("rescan");
    pulse_ack();

    // reset during SCAN discards the partial result and clears the outputs
    fill(12'h000); put(3, 2, 12'hF00); put(0, 1, 12'hF00);
    do_scan("pre_reset");
    push_exp();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    void'(exp_q0.pop_back());
    void'(exp_q1.pop_back());
    for (int i = 0; i < 2; i++) begin
      chk("abort.busy", i, 32'(busy_w[i]), 0);
      chk("abort.done", i, 32'(done_w[i]), 0);
      chk("abort.rd_addr", i, 32'(rd_addr_w[i]), 0);
      chk_outs("abort", i, zero_e);
    end
    do_scan("post_reset");

    repeat (5) @(posedge clk);
    tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      fails++;
      $display("FAIL pending: got %0d/%0d unanswered scans, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bbox_scan.md
# bbox_scan

Bounding-box scanner for the camera pipeline. After a photo is committed to the second frame buffer, it reads every pixel through the buffer's read port (`filter_read_addr` / `filter_read_data`) and classifies each pixel against a colour threshold. It then reports the min/max column and row of matching pixels, plus a match count. The top-level FSM drives it through the `min_max_start` / `min_max_done` / `min_max_ack` handshake on `clk_out_25MHZ`, and consumes `x_min`, `x_max`, `y_min` and `y_max`.

## Interface
Parameters:
- `H_RES`, 320: pixels per row.
- `V_RES`, 240: rows per frame.
- `RD_LATENCY`, 1: frame-buffer read latency in cycles (1..3).
- `R_MIN`, 4'd10: match requires red ≥ `R_MIN`.
- `G_MAX`, 4'd6: match requires green ≤ `G_MAX`.
- `B_MAX`, 4'd6: match requires blue ≤ `B_MAX`.

Ports:
- `clk`, in, 1: `clk_out_25MHZ` domain; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: scan request (level).
- `ack`, in, 1: result acknowledge (level).
- `busy`, out, 1: high in SCAN and DRAIN.
- `done`, out, 1: results valid; held until ack.
- `rd_addr`, out, 17: frame-buffer read address = y*H_RES + x.
- `rd_data`, in, 12: pixel {R[11:8], G[7:4], B[3:0]}, valid `RD_LATENCY` cycles after `rd_addr`.
- `x_min`, `x_max`, out, 9: matched column bounds.
- `y_min`, `y_max`, out, 9: matched row bounds (zero-extended).
- `found`, out, 1: at least one pixel matched.
- `pix_count`, out, 17: number of matched pixels.

## Operation
- States:
  - IDLE: `start`=1 and `ack`=0 → SCAN. Clears column/row counters and `rd_addr`, and loads the accumulators: `acc_xmin`=H_RES-1, `acc_xmax`=0, `acc_ymin`=V_RES-1, `acc_ymax`=0, `acc_cnt`=0, `acc_found`=0.
  - SCAN: presents one address per cycle, 0..N-1 (N=H_RES*V_RES), in raster order.
    - The column counter wraps at H_RES-1 and increments the row counter.
    - After address N-1 is issued → DRAIN.
  - DRAIN: waits `RD_LATENCY` cycles so the last read returns, then → DONE.
    - On entry to DONE, copies the accumulators to the output registers.
  - DONE: `done`=1. `ack`=1 → IDLE; `done` drops on that edge.
  - Any illegal encoding → IDLE.
- Valid pipeline:
  - A `RD_LATENCY`-deep shift register carries {valid, x, y} alongside each issued address.
  - A pixel is processed only when its delayed valid bit is 1.
- Match:
  - `rd_data[11:8]` ≥ `R_MIN` and `rd_data[7:4]` ≤ `G_MAX` and `rd_data[3:0]` ≤ `B_MAX`; comparisons are unsigned 4-bit.
  - On a match: `acc_xmin` = min(`acc_xmin`, x), `acc_xmax` = max, same for y, `acc_cnt`+1, `acc_found`=1.
- No match in the whole frame: `found`=0, and `x_min`/`x_max`/`y_min`/`y_max`/`pix_count` are all forced to 0.
- The output registers change only on entry to DONE and on reset; they hold their values through IDLE and the next scan.
- `start` held high through DONE does not retrigger; a new scan requires IDLE with `ack`=0.
- `start` is ignored outside IDLE.
- `ack` is ignored outside DONE.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`=0, `done`=0, `found`=0.
  - `rd_addr`=0.
  - All bound outputs = 0, `pix_count`=0.
  - Valid pipeline cleared.
- Reset mid-SCAN or mid-DRAIN aborts at the next edge. The outputs take their reset values, not partial results.
- Cycle 0 is the first SCAN cycle: `rd_addr`=0, `busy`=1.
- Cycle N-1: `rd_addr`=N-1.
- Cycles N..N+RD_LATENCY-1: DRAIN, `busy`=1.
- Cycle N+RD_LATENCY: `done`=1, `busy`=0, outputs valid.
- Default parameters: `done` rises 76 801 cycles after SCAN entry (N=76 800, `RD_LATENCY`=1).
- `rd_addr` is registered and is held at its last value outside SCAN.
- Throughput: one pixel per cycle, no stalls.
- `done` and `ack` both high at an edge → IDLE. If `start`=1 and `ack`=0 in the following IDLE cycle, the next scan begins one cycle later.

## Test plan
Bench uses `H_RES`=8, `V_RES`=4, a behavioural RAM model with `RD_LATENCY` = 1 and 2, and the default thresholds.
- Single red pixel (F00) at x=5, y=2, rest 000 → `done` at cycle 33 (`RD_LATENCY`=1); outputs x=5..5, y=2..2, `found`=1, `pix_count`=1.
- Red pixels at (1,0), (6,1), (3,3) → `x_min`=1, `x_max`=6, `y_min`=0, `y_max`=3, `pix_count`=3.
- Boundary colours: A66 matches; 966, A76 and A67 do not. Frame contains one of each → `pix_count`=1.
- All pixels 000 → `found`=0, all bounds 0, `pix_count`=0. Full frame F00 → bounds 0..7 and 0..3, `pix_count`=32.
- `start` held high with `ack` low → `done` stays high with no rescan. Then `ack` pulses 1 cycle → `done` falls, a new scan starts with `busy` two cycles later, and the outputs keep their old values until the new DONE.
- `reset` asserted at cycle 10 of SCAN → next cycle: IDLE, `busy`=0, `done`=0, all outputs 0. A fresh scan afterwards gives correct results.
